uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage. It consumes the TX line driven by the project's UART sender and recovers each frame into a parallel word.
- The line is oversampled with a CLK running at OVERSAMPLE × baud. For example, an 8 MHz CLK receives a 500 kbaud stream.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB-first (data[1] first on the wire), 1 stop bit (1).
- Outputs are a one-cycle data_valid strobe with held data, plus a framing-error strobe.

Parameters:
- OVERSAMPLE, 16, CLK cycles per bit period. Must be an even number, 4 or greater.
- DATA_BITS, 8, data bits per frame.

Ports:
- CLK  input  1  oversampling clock, OVERSAMPLE × baud.
- RST  input  1  asynchronous, active-high reset.
- RX  input  1  asynchronous serial line. Idles at 1.
- data  output  [DATA_BITS:1]  last good frame; data[1] is the first bit received.
- data_valid  output  1  one-cycle pulse when `data` is updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- One clock domain (CLK). Reset is asynchronous and active-high on RST. All flops reset together.
- Reset values:
  - data = 0, data_valid = 0, frame_err = 0, busy = 0.
  - Synchronizer flops = 1, state = IDLE, counters = 0.
- RX passes through a 2-flop synchronizer; its output is rx_s. Only rx_s is used downstream.
- H = OVERSAMPLE/2. tick = counter from 0 to OVERSAMPLE-1. bitn = counter from 0 to DATA_BITS-1.
- States:
  - IDLE: when rx_s = 0, go to START with tick = 0.
  - START: tick increments each cycle. In the cycle where tick = H-1:
    - if rx_s = 0, go to DATA with tick = 0, bitn = 0;
    - else it is a glitch: return to IDLE with no strobe.
  - DATA: tick increments each cycle. In the cycle where tick = OVERSAMPLE-1:
    - shift rx_s into the shift register at the MSB end, shifting right (so the first bit ends at [1]);
    - set tick = 0;
    - if bitn = DATA_BITS-1, go to STOP; else bitn++.
  - STOP: in the cycle where tick = OVERSAMPLE-1:
    - if rx_s = 1: data <= shift register, data_valid <= 1, go to IDLE;
    - if rx_s = 0: frame_err <= 1, data is unchanged, go to BREAK.
  - BREAK: wait for rx_s = 1, then go to IDLE. This prevents a held-low line from re-triggering start detection.
- Strobes are registered and last exactly one cycle.
- Latency: let RX fall just before CLK edge k. Then:
  - START is entered at edge k+2;
  - the start midpoint is checked at edge k+2+H;
  - data bit i (1-based) is sampled at edge k+2+H+i·OVERSAMPLE;
  - the stop bit is sampled at edge k+2+H+(DATA_BITS+1)·OVERSAMPLE;
  - data_valid is high for the one cycle after that edge.
  - Defaults: k+154.
- Back-to-back frames: return to IDLE happens at the stop midpoint, leaving H cycles of margin to detect the next start edge. No frame is lost.
- Shift-register contents are discarded on a glitch, on a framing error, and on reset.
- RST asserted mid-frame: everything returns to reset values immediately with no strobe. After release, reception resumes only on a new falling edge of rx_s seen from IDLE.
- No flow control. A consumer that misses data_valid sees data overwritten by the next good frame.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK);
  - the default oversample constant;
  - the frame constants START_BIT = 0 and STOP_BIT = 1.
- One sub-module, rx_sync: a 2-flop synchronizer with asynchronous reset to 1, parameterised reset value. It is reusable for other asynchronous inputs.

Test Plan:
- Clean frame: send 0xA5 LSB-first at OVERSAMPLE=16 → data = 0xA5, data_valid high exactly 1 cycle, at edge k+154; frame_err stays 0.
- Start glitch: RX low for 4 cycles, then high → return to IDLE; no data_valid, no frame_err; data unchanged.
- Framing error: frame 0x3C with stop bit driven 0 and held low for 40 cycles → frame_err pulses once; data keeps its prior value; busy stays high until RX returns to 1.
- Back-to-back frames: 0x00, 0xFF, 0x55 with no idle gap → three data_valid pulses, each 160 cycles apart, with the correct values.
- Reset mid-frame: assert RST during data bit 4, release, then send 0x81 → no strobe from the aborted frame; 0x81 is received correctly.
- Loopback: sender on a 500 kHz CLK feeding the receiver on an 8 MHz CLK, pulsing start to send 0x5A → receiver data = 0x5A, one data_valid pulse, no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam int   DEFAULT_OVERSAMPLE = 16;
    localparam logic START_BIT          = 1'b0;
    localparam logic STOP_BIT           = 1'b1;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// parameterised value loaded on asynchronous reset.
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    // Metastability filter: first stage may go metastable, second stage is clean.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start-bit qualification at mid-bit, LSB-first
// data capture, stop-bit check with framing-error and break handling.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX,
    output logic [DATA_BITS:1]   data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                w_rx_s;
    state_t              r_state;
    logic [TW-1:0]       r_tick;
    logic [BW-1:0]       r_bitn;
    logic [DATA_BITS:1]  r_shift;
    logic [DATA_BITS:1]  r_data;
    logic                r_valid;
    logic                r_ferr;
    logic                r_busy;

    rx_sync #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (RX),
        .o_q   (w_rx_s)
    );

    // Receive FSM; strobes default low so each lasts exactly one cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_bitn  <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rx_s == START_BIT) begin
                        r_state <= START;
                        r_tick  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_tick == TICK_HALF) begin
                        r_tick <= '0;
                        r_bitn <= '0;
                        if (w_rx_s == START_BIT) begin
                            r_state <= DATA;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_shift <= '0;
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                DATA: begin
                    if (r_tick == TICK_LAST) begin
                        r_tick  <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS:2]};
                        if (r_bitn == BIT_LAST) begin
                            r_state <= STOP;
                        end else begin
                            r_bitn <= r_bitn + BW'(1);
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                STOP: begin
                    if (r_tick == TICK_LAST) begin
                        r_tick <= '0;
                        if (w_rx_s == STOP_BIT) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_shift <= '0;
                            r_state <= BREAK;
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                // A held-low line must go high before a new start is accepted.
                BREAK: begin
                    if (w_rx_s == STOP_BIT) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tick  <= '0;
                    r_bitn  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data       = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized scoreboard bench for uart_receiver: a driver serialises frames
// and queues expected outcomes; a monitor checks each strobe as it appears.
module tb_uart_receiver;

    localparam int OS  = 16;
    localparam int DB  = 8;
    localparam int H   = OS / 2;
    localparam int LAT = 2 + H + (DB + 1) * OS;

    typedef struct {
        bit           is_err;
        logic [DB:1]  d;
        longint       cyc;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RX  = 1'b1;
    logic [DB:1]   data;
    logic          data_valid;
    logic          frame_err;
    logic          busy;
    logic          clk_tx = 1'b0;

    longint        cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    exp_t          q[$];
    logic [DB:1]   last_good = '0;

    uart_receiver #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX         (RX),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #37;
        forever #80 clk_tx = ~clk_tx;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RST && (data_valid || frame_err)) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", 0, 1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("both_strobes", longint'(data_valid & frame_err), 0);
                check(e.is_err ? "frame_err_kind" : "data_valid_kind",
                      longint'(frame_err), longint'(e.is_err));
                check(e.is_err ? "data_held" : "data_value", longint'(data), longint'(e.d));
                if (e.cyc >= 0) check("strobe_latency", cyc, e.cyc);
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int hold_low);
        exp_t e;
        e.is_err = !stop_ok;
        e.d      = stop_ok ? d : last_good;
        e.cyc    = cyc + 1 + LAT;
        q.push_back(e);
        if (stop_ok) last_good = d;
        RX = 1'b0;
        wait_cyc(OS);
        for (int i = 0; i < DB; i++) begin
            RX = d[i];
            wait_cyc(OS);
        end
        if (stop_ok) begin
            RX = 1'b1;
            wait_cyc(OS);
        end else begin
            RX = 1'b0;
            wait_cyc(hold_low);
            check("busy_in_break", longint'(busy), 1);
            RX = 1'b1;
            wait_cyc(4);
            check("busy_after_break", longint'(busy), 0);
        end
    endtask

    task automatic glitch(input int len);
        RX = 1'b0;
        wait_cyc(len);
        RX = 1'b1;
        wait_cyc(H + 6);
        check("glitch_idle", longint'(busy), 0);
        check("glitch_data", longint'(data), longint'(last_good));
    endtask

    // Bit-serial sender running on its own slow clock, as the real transmitter would.
    task automatic loop_send(input logic [7:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.d      = d;
        e.cyc    = -1;
        q.push_back(e);
        last_good = d;
        @(posedge clk_tx) RX = 1'b0;
        for (int i = 0; i < DB; i++) @(posedge clk_tx) RX = d[i];
        @(posedge clk_tx) RX = 1'b1;
        @(posedge clk_tx);
        @(posedge clk_tx);
        wait_cyc(2);
    endtask

    initial begin
        int r;
        int budget;
        logic [7:0] rd;

        wait_cyc(3);
        RST = 1'b0;
        wait_cyc(2);
        check("reset_data", longint'(data), 0);
        check("reset_valid", longint'(data_valid), 0);
        check("reset_ferr", longint'(frame_err), 0);
        check("reset_busy", longint'(busy), 0);

        send_frame(8'hA5, 1'b1, 0);
        wait_cyc(10);
        glitch(4);
        send_frame(8'h3C, 1'b0, 40);
        wait_cyc(5);
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h55, 1'b1, 0);
        wait_cyc(20);

        // Reset in the middle of data bit 4; the aborted frame must leave no trace.
        RX = 1'b0;
        wait_cyc(OS);
        for (int i = 0; i < 3; i++) begin
            RX = 1'(i & 1);
            wait_cyc(OS);
        end
        RX = 1'b1;
        wait_cyc(H);
        RST = 1'b1;
        wait_cyc(3);
        check("midreset_busy", longint'(busy), 0);
        check("midreset_data", longint'(data), 0);
        RST = 1'b0;
        last_good = '0;
        wait_cyc(4);
        check("post_reset_busy", longint'(busy), 0);
        send_frame(8'h81, 1'b1, 0);
        wait_cyc(10);

        loop_send(8'h5A);
        wait_cyc(OS * 3);

        for (int n = 0; n < 24; n++) begin
            r  = $urandom_range(0, 9);
            rd = 8'($urandom);
            if (r == 0) glitch($urandom_range(1, H - 2));
            else if (r == 1) send_frame(rd, 1'b0, $urandom_range(20, 60));
            else send_frame(rd, 1'b1, 0);
            wait_cyc($urandom_range(0, 12));
        end

        budget = 0;
        while (q.size() != 0 && budget < 400) begin
            wait_cyc(1);
            budget++;
        end
        check("pending_expectations", q.size(), 0);
        wait_cyc(5);
        check("final_idle", longint'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
